// File: rtl/irq_ctrl_if.sv
// Configuration register port of the interrupt controller,
// decoded from the data-memory bus.
interface irq_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised, maskable interrupt controller for the CPU IRQ input.
// Define IRQ_SYNC_EN to add 2-flop synchronisers on irq_in.
module irq_ctrl #(
  parameter int          N_IRQ        = 8,
  parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}},
  parameter int          VEC_STRIDE   = 8,
  parameter logic [31:0] VEC_BASE_RST = 32'h8000_0100
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             supervisor,
  output logic             irq_req,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic [31:0]      irq_vec,
  output logic [4:0]       irq_id,
  output logic             in_service,
  irq_ctrl_if.slave        cfg
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   irq_s;
  logic [N_IRQ-1:0]   prev_q;
  logic [N_IRQ-1:0]   pend_q, pend_d;
  logic [N_IRQ-1:0]   mask_q;
  logic [31:0]        base_q;
  logic [4:0]         id_q;
  logic [31:0]        vec_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [N_IRQ-1:0]   rise, eff, w1c, ack_clr;
  logic [4:0]         sel_id;
  logic [31:0]        sel_vec;
  logic               take;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise = irq_s & ~prev_q;
  assign eff  = pend_q & mask_q;

  // index 0 wins
  always_comb begin
    sel_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eff[i]) sel_id = 5'(i);
    end
  end

  assign sel_vec = base_q + 32'(sel_id) * 32'(VEC_STRIDE);

  assign take = (state_q == REQ) && irq_ack && (|eff);

  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    if (cfg.cfg_we && cfg.cfg_addr == 2'd1)
      w1c = cfg.cfg_wdata[N_IRQ-1:0];
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = take && (sel_id == 5'(i));
    end
  end

  // new edge beats any clear in the same cycle
  assign pend_d = (EDGE_MASK & ((pend_q & ~(w1c | ack_clr)) | rise))
                | (~EDGE_MASK & irq_s);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|eff) state_d = REQ;
      REQ: begin
        if (take)        state_d = SERVICE;
        else if (!(|eff)) state_d = IDLE;
      end
      SERVICE: if (eoi)  state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  assign irq_req    = (state_q == REQ) && !supervisor;
  assign in_service = (state_q == SERVICE);
  assign irq_id     = in_service ? id_q  : sel_id;
  assign irq_vec    = in_service ? vec_q : sel_vec;

  always_comb begin
    rdata_d = '0;
    unique case (cfg.cfg_addr)
      2'd0: rdata_d = 32'(mask_q);
      2'd1: rdata_d = 32'(pend_q);
      2'd2: rdata_d = {22'd0, irq_req, in_service, 3'd0, irq_id};
      2'd3: rdata_d = base_q;
      default: rdata_d = '0;
    endcase
  end

  assign cfg.cfg_rdata = rdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      base_q  <= VEC_BASE_RST;
      id_q    <= '0;
      vec_q   <= VEC_BASE_RST;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_s;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      if (cfg.cfg_we && cfg.cfg_addr == 2'd0)
        mask_q <= cfg.cfg_wdata[N_IRQ-1:0];
      if (cfg.cfg_we && cfg.cfg_addr == 2'd3)
        base_q <= {cfg.cfg_wdata[31:2], 2'b00};
      if (take) begin
        id_q  <= sel_id;
        vec_q <= sel_vec;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: per-cycle vector table fed through a
// scoreboard queue, plus a mid-service reset sequence.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        supervisor = 1'b0;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic [4:0]  irq_id;
  logic        in_service;

  irq_ctrl_if cfg_bus ();

  irq_ctrl #(
    .N_IRQ        (8),
    .EDGE_MASK    (8'hFB),
    .VEC_STRIDE   (8),
    .VEC_BASE_RST (32'h8000_0100)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .irq_in     (irq_in),
    .supervisor (supervisor),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq_vec    (irq_vec),
    .irq_id     (irq_id),
    .in_service (in_service),
    .cfg        (cfg_bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic        sup;
    logic        ack;
    logic        eoi;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        req;
    logic [4:0]  id;
    logic [31:0] vec;
    logic        svc;
    logic        rdc;
    logic [31:0] rd;
  } row_t;

  row_t        tbl[$];
  row_t        sb[$];
  logic [31:0] tb_base = 32'h8000_0100;
  int          checks = 0;
  int          errors = 0;

  function automatic void add(
    input int unsigned irq, sup, ack, eo, we, addr,
    input logic [31:0] wd,
    input int unsigned req, id, svc, rdc,
    input logic [31:0] rd
  );
    row_t r;
    r.irq  = 8'(irq);
    r.sup  = 1'(sup);
    r.ack  = 1'(ack);
    r.eoi  = 1'(eo);
    r.we   = 1'(we);
    r.addr = 2'(addr);
    r.wd   = wd;
    r.req  = 1'(req);
    r.id   = 5'(id);
    r.vec  = tb_base + 32'(id) * 32'd8;
    r.svc  = 1'(svc);
    r.rdc  = 1'(rdc);
    r.rd   = rd;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    row_t e;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_addr  = 2'd0;
    cfg_bus.cfg_wdata = '0;

    // irq sup ack eoi we addr wdata | req id svc rdchk rdata
    add(8'h00,0,0,0,1,0,32'h1,       0,0,0,1,32'h0);
    add(8'h01,0,0,0,0,0,32'h0,       0,0,0,1,32'h1);
    add(8'h00,0,0,0,0,1,32'h0,       1,0,0,1,32'h1);
    add(8'h00,0,1,0,0,1,32'h0,       0,0,1,1,32'h1);
    add(8'h00,0,0,0,0,1,32'h0,       0,0,1,1,32'h0);
    add(8'h00,0,0,1,0,2,32'h0,       0,0,0,1,32'h100);
    add(8'h00,0,0,0,0,2,32'h0,       0,0,0,1,32'h0);
    add(8'h00,0,0,0,1,0,32'hFF,      0,0,0,1,32'h1);
    add(8'h28,0,0,0,0,0,32'h0,       0,3,0,1,32'hFF);
    add(8'h00,0,0,0,0,1,32'h0,       1,3,0,1,32'h28);
    add(8'h00,0,1,0,0,1,32'h0,       0,3,1,1,32'h28);
    add(8'h00,0,0,1,0,1,32'h0,       0,5,0,1,32'h20);
    add(8'h00,0,0,0,0,0,32'h0,       1,5,0,0,32'h0);
    add(8'h02,0,0,0,0,0,32'h0,       1,1,0,0,32'h0);
    add(8'h00,0,1,0,0,1,32'h0,       0,1,1,1,32'h22);
    add(8'h00,0,1,0,0,1,32'h0,       0,1,1,1,32'h20);
    add(8'h00,0,0,1,0,1,32'h0,       0,5,0,1,32'h20);
    add(8'h00,1,0,0,0,2,32'h0,       0,5,0,1,32'h005);
    add(8'h00,1,0,0,0,2,32'h0,       0,5,0,1,32'h005);
    add(8'h00,0,0,0,0,2,32'h0,       1,5,0,1,32'h205);
    add(8'h00,0,1,0,0,0,32'h0,       0,5,1,0,32'h0);
    add(8'h00,0,1,1,0,2,32'h0,       0,0,0,1,32'h105);
    add(8'h04,0,0,0,0,0,32'h0,       0,2,0,0,32'h0);
    add(8'h04,0,0,0,0,0,32'h0,       1,2,0,0,32'h0);
    add(8'h04,0,1,1,0,0,32'h0,       0,2,1,0,32'h0);
    add(8'h04,0,0,1,0,0,32'h0,       0,2,0,0,32'h0);
    add(8'h04,0,0,0,0,0,32'h0,       1,2,0,0,32'h0);
    add(8'h00,0,0,0,0,0,32'h0,       1,0,0,0,32'h0);
    add(8'h00,0,0,0,0,0,32'h0,       0,0,0,0,32'h0);
    add(8'h00,0,0,0,1,0,32'h0,       0,0,0,1,32'hFF);
    add(8'h08,0,0,0,0,1,32'h0,       0,0,0,1,32'h0);
    add(8'h00,0,0,0,1,1,32'h8,       0,0,0,1,32'h8);
    add(8'h08,0,0,0,1,1,32'h8,       0,0,0,1,32'h0);
    add(8'h08,0,0,0,0,1,32'h0,       0,0,0,1,32'h8);
    add(8'h0C,0,0,0,1,1,32'h4,       0,0,0,1,32'h8);
    add(8'h0C,0,0,0,0,1,32'h0,       0,0,0,1,32'h0C);
    add(8'h00,0,0,0,1,1,32'hFF,      0,0,0,1,32'h0C);
    add(8'h00,0,0,0,0,1,32'h0,       0,0,0,1,32'h0);
    tb_base = 32'h1000;
    add(8'h00,0,0,0,1,3,32'h1003,    0,0,0,1,32'h8000_0100);
    add(8'h00,0,0,0,0,3,32'h0,       0,0,0,1,32'h1000);
    add(8'h00,0,0,0,1,0,32'hFFFF_FF01, 0,0,0,1,32'h0);
    add(8'h00,0,0,0,0,0,32'h0,       0,0,0,1,32'h1);

    #12;
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_id",  32'(irq_id), 32'h0);
    chk("rst_vec", irq_vec, 32'h8000_0100);
    chk("rst_svc", 32'(in_service), 32'h0);
    chk("rst_rd",  cfg_bus.cfg_rdata, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      irq_in            = tbl[i].irq;
      supervisor        = tbl[i].sup;
      irq_ack           = tbl[i].ack;
      eoi               = tbl[i].eoi;
      cfg_bus.cfg_we    = tbl[i].we;
      cfg_bus.cfg_addr  = tbl[i].addr;
      cfg_bus.cfg_wdata = tbl[i].wd;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("r%0d_req", i), 32'(irq_req), 32'(e.req));
      chk($sformatf("r%0d_id", i), 32'(irq_id), 32'(e.id));
      chk($sformatf("r%0d_vec", i), irq_vec, e.vec);
      chk($sformatf("r%0d_svc", i), 32'(in_service), 32'(e.svc));
      if (e.rdc)
        chk($sformatf("r%0d_rd", i), cfg_bus.cfg_rdata, e.rd);
    end

    // take source 0 into service, then reset asynchronously
    @(negedge clk);
    irq_ack = 1'b0; eoi = 1'b0; supervisor = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 2'd0;
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
    @(posedge clk);
    #1;
    chk("mr_req", 32'(irq_req), 32'h1);
    chk("mr_vec", irq_vec, 32'h1000);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("mr_svc", 32'(in_service), 32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_rst_svc", 32'(in_service), 32'h0);
    chk("mr_rst_req", 32'(irq_req), 32'h0);
    chk("mr_rst_id",  32'(irq_id), 32'h0);
    chk("mr_rst_vec", irq_vec, 32'h8000_0100);
    chk("mr_rst_rd",  cfg_bus.cfg_rdata, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    cfg_bus.cfg_addr = 2'd0;
    @(posedge clk);
    #1;
    chk("mr_mask", cfg_bus.cfg_rdata, 32'h0);
    @(negedge clk);
    cfg_bus.cfg_addr = 2'd3;
    @(posedge clk);
    #1;
    chk("mr_base", cfg_bus.cfg_rdata, 32'h8000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
